// File: rtl/key_stop_ctrl.sv
// ---------------------------------------------------------------------------
// key_stop_ctrl
//   Front end for the LED water-light chain. It synchronises and debounces
//   the raw active-low board button. It produces single-cycle press, release
//   and long-press events. It also keeps a `stop` level that toggles on each
//   accepted press and feeds the LED sequencer's `stop` input directly.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_n        raw button, asynchronous to clk, 0 = pressed
//   stop         pause level, toggles on each accepted press
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_long     one-cycle pulse after a press is held LONG_CYCLES cycles
//   key_state    debounced level, 1 = pressed
// ---------------------------------------------------------------------------
module key_stop_ctrl #(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   LONG_CYCLES     = 50000000,
  parameter int   CNT_W           = 26,
  parameter logic STOP_INIT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stop,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILT_DN = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] FILT_UP = 2'd3;

  // Terminal counts. A zero LONG_CYCLES disables the long-press event, so
  // its terminal value is parked at zero to avoid a negative constant.
  localparam logic             LONG_EN   = (LONG_CYCLES != 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = LONG_EN ? CNT_W'(LONG_CYCLES - 1)
                                                   : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_r;
  logic             sync_n_r;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] deb_cnt_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             long_flag_r;

  // Two-flop synchroniser. Both flops reset to the released level, so a key
  // held through reset must still be fully debounced before a press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b1;
      sync_n_r <= 1'b1;
    end else begin
      sync1_r  <= key_n;
      sync_n_r <= sync1_r;
    end
  end

  // Debounce FSM with registered event pulses, debounced level and stop toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      deb_cnt_r   <= {CNT_W{1'b0}};
      hold_cnt_r  <= {CNT_W{1'b0}};
      long_flag_r <= 1'b0;
      stop        <= STOP_INIT;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      // Pulses default low so each one lasts exactly one cycle.
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (state_r)
        IDLE: begin
          key_state <= 1'b0;
          if (!sync_n_r) begin
            state_r   <= FILT_DN;
            deb_cnt_r <= {CNT_W{1'b0}};
          end
        end
        FILT_DN: begin
          if (sync_n_r) begin
            state_r <= IDLE;
          end else if (deb_cnt_r == DEB_LAST) begin
            state_r     <= DOWN;
            key_press   <= 1'b1;
            stop        <= ~stop;
            key_state   <= 1'b1;
            hold_cnt_r  <= {CNT_W{1'b0}};
            long_flag_r <= 1'b0;
          end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
          end
        end
        DOWN: begin
          if (sync_n_r) begin
            state_r   <= FILT_UP;
            deb_cnt_r <= {CNT_W{1'b0}};
          end else begin
            // Saturate so a very long hold never wraps into a second event.
            if (hold_cnt_r != HOLD_LAST) begin
              hold_cnt_r <= hold_cnt_r + CNT_ONE;
            end
            // The long flag limits the long event to one per press.
            if (LONG_EN && (hold_cnt_r == HOLD_LAST) && !long_flag_r) begin
              key_long    <= 1'b1;
              long_flag_r <= 1'b1;
            end
          end
        end
        FILT_UP: begin
          // A bounce back to pressed keeps the hold count and the long flag.
          if (!sync_n_r) begin
            state_r <= DOWN;
          end else if (deb_cnt_r == DEB_LAST) begin
            state_r     <= IDLE;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          key_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_stop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_stop_ctrl
//   Directed, table-driven bench for key_stop_ctrl with DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=16 and STOP_INIT=0. Each table row describes a key waveform
//   in four phases: low, glitch-high, low, high. It also gives the expected
//   sample index of the press, release and long pulses, counted from the
//   first edge after the waveform starts. Hand-written sequences cover the
//   bounce train, reset in mid-press, and a small LED stage driven by `stop`.
// ---------------------------------------------------------------------------
module tb_key_stop_ctrl;

  logic clk;
  logic rst_n;
  logic key_n;
  logic stop;
  logic key_press;
  logic key_release;
  logic key_long;
  logic key_state;

  int total = 0;
  int bad   = 0;
  logic stop_model;
  logic [7:0] led_cnt;
  logic [7:0] led_at_press;

  typedef struct {
    int l1;   // cycles low
    int g;    // cycles of high glitch
    int l2;   // cycles low after the glitch
    int h;    // cycles high at the end
    int p;    // expected key_press sample index (0 = none)
    int r;    // expected key_release sample index (0 = none)
    int lg;   // expected key_long sample index (0 = none)
  } vec_t;

  vec_t tbl[7];

  key_stop_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .CNT_W          (26),
    .STOP_INIT      (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .stop       (stop),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  // Stand-in for the LED sequencer: it advances only while not stopped.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_cnt <= 8'd0;
    else if (!stop) led_cnt <= led_cnt + 8'd1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Drive the key, then sample one time unit after the next rising edge.
  task automatic step(input logic k);
    key_n = k;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, key_press, key_release, key_long, key_state, stop};
  endfunction

  task automatic run_vec(input string name, input vec_t v);
    int n;
    logic k;
    logic st;
    n = v.l1 + v.g + v.l2 + v.h;
    for (int t = 1; t <= n; t++) begin
      if (t <= v.l1) k = 1'b0;
      else if (t <= v.l1 + v.g) k = 1'b1;
      else if (t <= v.l1 + v.g + v.l2) k = 1'b0;
      else k = 1'b1;
      step(k);
      if (t == v.p) begin
        stop_model   = ~stop_model;
        led_at_press = led_cnt;
      end
      st = (v.p != 0) && (t >= v.p) && ((v.r == 0) || (t < v.r));
      check($sformatf("%s t=%0d", name, t), outs(),
            {3'b000, (t == v.p), (t == v.r), (t == v.lg), st, stop_model});
    end
  endtask

  initial begin
    tbl[0] = '{30, 0,  0, 10, 7, 37, 23};  // clean press, long hold
    tbl[1] = '{10, 0,  0, 10, 7, 17,  0};  // double press, first
    tbl[2] = '{10, 0,  0, 10, 7, 17,  0};  // double press, second
    tbl[3] = '{ 4, 0,  0, 10, 0,  0,  0};  // one cycle too short to accept
    tbl[4] = '{ 5, 0,  0, 10, 7, 12,  0};  // shortest accepted press
    tbl[5] = '{40, 0,  0, 10, 7, 47, 23};  // long press
    tbl[6] = '{12, 1, 30, 10, 7, 50, 25};  // long press with 1-cycle glitch

    key_n      = 1'b1;
    rst_n      = 1'b0;
    stop_model = 1'b0;
    #5;
    check("reset outputs", outs(), 8'h00);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bounce train: low/high every two cycles never survives the filter.
    for (int t = 1; t <= 30; t++) begin
      step((t <= 20) ? (((t - 1) / 2) % 2 == 1) : 1'b1);
      check($sformatf("bounce t=%0d", t), outs(), 8'h00);
    end

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in mid-press: stop is 1 and the FSM is in DOWN.
    for (int t = 1; t <= 10; t++) begin
      step(1'b0);
      if (t == 7) stop_model = ~stop_model;
      check($sformatf("pre-reset t=%0d", t), {7'd0, key_press}, {7'd0, t == 7});
    end
    check("pre-reset stop/state", {6'd0, key_state, stop}, {6'd0, 1'b1, stop_model});
    #4;
    rst_n = 1'b0;
    #1;
    check("async reset", outs(), 8'h00);
    stop_model = 1'b0;
    #9;
    rst_n = 1'b1;
    // The key is still held, so a full debounce is needed before the press.
    run_vec("post-reset", '{10, 0, 0, 10, 7, 17, 0});

    // LED stage: it is frozen now, resumes after the next press and freezes
    // again from the press cycle of the press after that.
    led_at_press = led_cnt;
    for (int t = 1; t <= 5; t++) step(1'b1);
    check("led frozen", led_cnt, led_at_press);
    run_vec("led resume", '{10, 0, 0, 10, 7, 17, 0});
    check("led moving", {7'd0, led_cnt != led_at_press}, 8'd1);
    run_vec("led pause", '{10, 0, 0, 10, 7, 17, 0});
    check("led frozen at press", led_cnt, led_at_press);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
